// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
//
// Round-robin sequencer for a shared 2:1 mux channel. It grants one of two
// requesters at a time, drives the mux select and registers the selected
// requester's data onto the shared output y. If a grant is contended, it is
// preempted after MAX_HOLD consecutive cycles. An uncontended grant has no
// time limit.
//
// Parameters
//   W         data width of d0, d1 and y
//   MAX_HOLD  max consecutive grant cycles while the other side waits (>= 1)
//
// Ports
//   clk      in   rising-edge clock, only clock domain
//   rst      in   synchronous active-high reset
//   req0     in   requester 0 request, held high while access is needed
//   req1     in   requester 1 request
//   d0       in   requester 0 data [W]
//   d1       in   requester 1 data [W]
//   gnt0     out  grant to requester 0 (decoded from the state register)
//   gnt1     out  grant to requester 1 (decoded from the state register)
//   sel      out  mux select, 0 = d0, 1 = d1
//   y        out  registered shared output [W]
//   y_valid  out  y was loaded with granted data on the last edge
//   busy     out  gnt0 | gnt1
// -----------------------------------------------------------------------------
module mux2_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] y,
  output logic         y_valid,
  output logic         busy
);

  // The hold counter only has to reach MAX_HOLD, because it saturates there.
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_last;        // requester that held the most recent grant
  logic           w_last_next;
  logic [CW-1:0]  r_hold_cnt;    // grant cycles so far in the current tenure
  logic [CW-1:0]  w_hold_cnt_next;
  logic           r_sel;
  logic           w_sel_next;
  logic [W-1:0]   r_y;
  logic           r_y_valid;

  logic           w_hold_max;
  logic           w_cap0;
  logic           w_cap1;

  assign w_hold_max = (r_hold_cnt == CW'(MAX_HOLD));

  // Data is captured only while the owner still requests. A requester that
  // drops req during its grant does not have that cycle's data taken.
  assign w_cap0 = (r_state == G0) && req0;
  assign w_cap1 = (r_state == G1) && req1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_last_next     = r_last;
    w_hold_cnt_next = r_hold_cnt;
    w_sel_next      = r_sel;

    case (r_state)
      IDLE: begin
        // On a tie, the requester that did not go last wins. After reset,
        // last=1, so requester 0 wins the first tie.
        if (req0 && req1) begin
          w_state_next = r_last ? G0 : G1;
        end else if (req0) begin
          w_state_next = G0;
        end else if (req1) begin
          w_state_next = G1;
        end
      end

      G0: begin
        if (!req0) begin
          // The owner releases the channel. Hand it straight to the waiter,
          // with no idle bubble, or fall back to IDLE.
          w_last_next  = 1'b0;
          w_state_next = req1 ? G1 : IDLE;
        end else if (req1 && w_hold_max) begin
          // Contended and the tenure is used up: preempt.
          w_last_next  = 1'b0;
          w_state_next = G1;
        end
      end

      G1: begin
        if (!req1) begin
          w_last_next  = 1'b1;
          w_state_next = req0 ? G0 : IDLE;
        end else if (req0 && w_hold_max) begin
          w_last_next  = 1'b1;
          w_state_next = G0;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Tenure counter. It restarts at 1 on every new grant, clears in IDLE and
    // saturates so that a late-arriving contender is served promptly.
    if (w_state_next == IDLE) begin
      w_hold_cnt_next = '0;
    end else if (w_state_next != r_state) begin
      w_hold_cnt_next = CW'(1);
    end else if (!w_hold_max) begin
      w_hold_cnt_next = r_hold_cnt + CW'(1);
    end

    // The select follows the grant on entry and keeps its last value in IDLE.
    if ((w_state_next == G0) && (r_state != G0)) begin
      w_sel_next = 1'b0;
    end else if ((w_state_next == G1) && (r_state != G1)) begin
      w_sel_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
      r_sel      <= 1'b0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_last     <= w_last_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_sel      <= w_sel_next;
      if (w_cap0) begin
        r_y       <= d0;
        r_y_valid <= 1'b1;
      end else if (w_cap1) begin
        r_y       <= d1;
        r_y_valid <= 1'b1;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign gnt0    = (r_state == G0);
  assign gnt1    = (r_state == G1);
  assign busy    = gnt0 | gnt1;
  assign sel     = r_sel;
  assign y       = r_y;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_arbiter
//
// Directed scenarios followed by a randomized stretch. A transaction-level
// reference model tracks the owner, its tenure length and the output register.
// All DUT outputs are compared against this model one time unit after every
// rising edge.
// -----------------------------------------------------------------------------
module tb_mux2_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic         gnt0, gnt1, sel, y_valid, busy;
  logic [W-1:0] y;

  mux2_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .d0      (d0),
    .d1      (d1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state. The owner is -1 when nobody holds the grant.
  // The tenure counts upward without bound.
  int           m_owner  = -1;
  int           m_tenure = 0;
  int           m_last   = 1;
  logic [W-1:0] m_y      = '0;
  logic         m_yv     = 1'b0;
  logic         m_sel    = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic         r[2];
    logic [W-1:0] d[2];
    int           nxt;
    int           oth;
    r[0] = req0; r[1] = req1;
    d[0] = d0;   d[1] = d1;
    if (rst) begin
      m_owner = -1; m_tenure = 0; m_last = 1;
      m_y = '0; m_yv = 1'b0; m_sel = 1'b0;
      return;
    end
    if (m_owner >= 0 && r[m_owner]) begin
      m_y  = d[m_owner];
      m_yv = 1'b1;
    end else begin
      m_yv = 1'b0;
    end
    if (m_owner < 0) begin
      if (r[0] && r[1]) nxt = 1 - m_last;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
      else              nxt = -1;
    end else begin
      oth = 1 - m_owner;
      if (!r[m_owner])                           nxt = r[oth] ? oth : -1;
      else if (r[oth] && m_tenure >= MAX_HOLD)  nxt = oth;
      else                                       nxt = m_owner;
    end
    if (nxt != m_owner) begin
      if (m_owner >= 0) m_last = m_owner;
      m_tenure = (nxt >= 0) ? 1 : 0;
      if (nxt >= 0) m_sel = (nxt == 1);
      m_owner = nxt;
    end else if (m_owner >= 0) begin
      m_tenure++;
    end
  endtask

  // One clock: update the model with the inputs the DUT sees at this edge,
  // then compare every output a little after the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt0",    {7'd0, gnt0},    {7'd0, (m_owner == 0)});
    check("gnt1",    {7'd0, gnt1},    {7'd0, (m_owner == 1)});
    check("busy",    {7'd0, busy},    {7'd0, (m_owner >= 0)});
    check("sel",     {7'd0, sel},     {7'd0, m_sel});
    check("y",       y,               m_y);
    check("y_valid", {7'd0, y_valid}, {7'd0, m_yv});
    check("excl",    {7'd0, gnt0 & gnt1}, 8'd0);
    $display("t=%0t rst=%0b req=%0b%0b d0=%h d1=%h | gnt=%0b%0b sel=%0b y=%h yv=%0b",
             $time, rst, req1, req0, d0, d1, gnt1, gnt0, sel, y, y_valid);
  endtask

  initial begin
    // 1: reset held for two cycles with both requests high
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    cycle(); cycle();
    check("t1_gnt0", {7'd0, gnt0}, 8'd0);
    check("t1_gnt1", {7'd0, gnt1}, 8'd0);
    check("t1_y",    y,            8'h00);

    // 2: req1 only, grant next cycle, then data one cycle after that
    rst = 1'b0; req0 = 1'b0; req1 = 1'b1; d1 = 8'hA5;
    cycle();
    check("t2_gnt1", {7'd0, gnt1}, 8'd1);
    check("t2_sel",  {7'd0, sel},  8'd1);
    cycle();
    check("t2_y",    y,            8'hA5);
    check("t2_yv",   {7'd0, y_valid}, 8'd1);
    req1 = 1'b0;
    cycle();

    // 3: both requesting from IDLE just after reset. The grant alternates in
    //    blocks of MAX_HOLD, starting with requester 0.
    rst = 1'b1; cycle();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4 * MAX_HOLD; i++) begin
      d0 = W'($urandom); d1 = W'($urandom);
      cycle();
      check("t3_alt0", {7'd0, gnt0}, {7'd0, ((i / MAX_HOLD) % 2 == 0)});
      check("t3_alt1", {7'd0, gnt1}, {7'd0, ((i / MAX_HOLD) % 2 == 1)});
    end

    // 4: hand-off with no gap, then release to IDLE with sel kept at 1
    req0 = 1'b0; req1 = 1'b0; cycle();
    req0 = 1'b1; cycle(); cycle();
    req0 = 1'b0; req1 = 1'b1; d1 = 8'h5A;
    cycle();
    check("t4_handoff", {7'd0, gnt1}, 8'd1);
    cycle();
    req1 = 1'b0;
    cycle();
    check("t4_busy", {7'd0, busy}, 8'd0);
    check("t4_sel",  {7'd0, sel},  8'd1);
    check("t4_yv",   {7'd0, y_valid}, 8'd0);
    check("t4_y",    y,            8'h5A);

    // 5: an uncontended grant is never preempted
    req0 = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      d0 = W'($urandom);
      cycle();
      check("t5_hold", {7'd0, gnt0}, 8'd1);
    end
    req0 = 1'b0; cycle();

    // 6: reset in the middle of a G1 stream, then a tie goes to requester 0
    req1 = 1'b1; d1 = 8'h3C;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    check("t6_gnt1", {7'd0, gnt1}, 8'd0);
    check("t6_y",    y,            8'h00);
    check("t6_sel",  {7'd0, sel},  8'd0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    cycle();
    check("t6_tie", {7'd0, gnt0}, 8'd1);

    // Randomized stretch: sticky requests with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 25) req0 = ~req0;
      if ($urandom_range(99) < 25) req1 = ~req1;
      rst = ($urandom_range(59) == 0);
      d0  = W'($urandom);
      d1  = W'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
